zigzag_rle_encoder: RTL and testbench

//  Downstream of the DCT/quantization stage: takes one quantized 8x8 MCU of 24.8 fixed-point coefficients,

---
 rtl/zigzag_rle_encoder.sv | 144 ++++++++++++++
 tb/tb_zigzag_rle_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_rle_encoder.sv
// Zigzag scan + run-length encoder for one quantized 8x8 MCU of fixed-point coefficients.
// Emits (run, value) pairs in JPEG zigzag order, then an end-of-block marker.
module zigzag_rle_encoder #(
  parameter int COEF_W    = 32,
  parameter int FRAC_BITS = 8,
  parameter int VAL_W     = 16,
  parameter int RUN_W     = 6,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [64*COEF_W-1:0]   mcu_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RUN_W-1:0]       out_run,
  output logic [VAL_W-1:0]       out_value,
  output logic                   out_eob,
  output logic                   busy,
  output logic [CNT_W-1:0]       block_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    EMIT_EOB = 2'd2
  } state_t;

  // Natural (row*8+col) position of each zigzag index.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam int HALF = 1 << (FRAC_BITS - 1);
  localparam logic signed [COEF_W:0] VMAX = (COEF_W+1)'((1 << (VAL_W - 1)) - 1);
  localparam logic signed [COEF_W:0] VMIN = -(COEF_W+1)'(1 << (VAL_W - 1));

  state_t               state;
  logic [COEF_W-1:0]    coef_buf [64];
  logic [5:0]           idx;
  logic [RUN_W-1:0]     run;

  logic [COEF_W-1:0]    cur_coef;
  logic signed [COEF_W:0] coef_ext;
  logic signed [COEF_W:0] rounded;
  logic [VAL_W-1:0]     val;
  logic                 advance;
  logic                 emit;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign advance  = !out_valid || out_ready;

  // One extra bit keeps the rounding add from overflowing near full scale.
  always_comb begin
    cur_coef = coef_buf[ZZ[idx]];
    coef_ext = $signed({cur_coef[COEF_W-1], cur_coef});
    rounded  = (coef_ext + (COEF_W+1)'(HALF)) >>> FRAC_BITS;
    if (rounded > VMAX)
      val = VMAX[VAL_W-1:0];
    else if (rounded < VMIN)
      val = VMIN[VAL_W-1:0];
    else
      val = rounded[VAL_W-1:0];
    emit = (idx == 6'd0) || (val != '0);
  end

  // NOTE: the coefficient buffer carries no reset; every entry is rewritten on accept
  // before it is read, so resetting 64 wide words would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      for (int i = 0; i < 64; i++)
        coef_buf[i] <= mcu_in[i*COEF_W +: COEF_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      run         <= '0;
      out_valid   <= 1'b0;
      out_run     <= '0;
      out_value   <= '0;
      out_eob     <= 1'b0;
      block_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= SCAN;
            idx   <= '0;
            run   <= '0;
          end
        end

        SCAN: begin
          if (advance) begin
            if (emit) begin
              out_run   <= run;
              out_value <= val;
              out_eob   <= 1'b0;
              out_valid <= 1'b1;
              run       <= '0;
            end else begin
              run       <= run + 1'b1;
              out_valid <= 1'b0;
            end
            if (idx == 6'd63)
              state <= EMIT_EOB;
            else
              idx <= idx + 1'b1;
          end
        end

        EMIT_EOB: begin
          // The marker's own handshake closes the block; any earlier pair must drain first.
          if (out_valid && out_eob && out_ready) begin
            out_valid   <= 1'b0;
            out_eob     <= 1'b0;
            block_count <= block_count + 1'b1;
            state       <= IDLE;
          end else if (advance) begin
            out_run   <= '0;
            out_value <= '0;
            out_eob   <= 1'b1;
            out_valid <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Randomized self-checking bench for zigzag_rle_encoder against a zigzag/RLE reference model.
module tb_zigzag_rle_encoder;

  localparam int COEF_W = 32;
  localparam int VAL_W  = 16;
  localparam int RUN_W  = 6;
  localparam int CNT_W  = 16;

  typedef struct {
    int run;
    int value;
    int eob;
  } tok_t;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [64*COEF_W-1:0] mcu_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [RUN_W-1:0]     out_run;
  logic [VAL_W-1:0]     out_value;
  logic                 out_eob;
  logic                 busy;
  logic [CNT_W-1:0]     block_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   zz_pos [64];
  tok_t exp_q [$];
  int   bc_exp   = 0;
  bit   rnd_ready = 1'b0;

  zigzag_rle_encoder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mcu_in      (mcu_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_run     (out_run),
    .out_value   (out_value),
    .out_eob     (out_eob),
    .busy        (busy),
    .block_count (block_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Zigzag order by walking anti-diagonals, alternating direction.
  function automatic void make_zigzag();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_pos[k] = r*8 + (s-r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_pos[k] = r*8 + (s-r); k++; end
      end
    end
  endfunction

  function automatic int round_sat(input logic [31:0] c);
    longint v = (longint'($signed(c)) + 128) >>> 8;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return int'(v);
  endfunction

  function automatic void build_expected(input logic [64*COEF_W-1:0] blk);
    int run = 0;
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      int v = round_sat(blk[zz_pos[k]*COEF_W +: COEF_W]);
      if (k == 0 || v != 0) begin
        exp_q.push_back('{run: run, value: v, eob: 0});
        run = 0;
      end else begin
        run++;
      end
    end
    exp_q.push_back('{run: 0, value: 0, eob: 1});
  endfunction

  function automatic logic [31:0] rand_coef();
    int r = int'($urandom_range(0, 99));
    if (r < 55) return 32'($signed(int'($urandom_range(0, 255)) - 128));
    if (r < 85) return 32'($signed(int'($urandom_range(0, 32767)) - 16384));
    if (r < 95) return $urandom();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0080;
      3: return 32'hFFFF_FF80;
      default: return 32'h0080_0000;
    endcase
  endfunction

  // Sends one block and scores the output stream; stop_after < 0 runs it to EOB.
  task automatic run_block(input logic [64*COEF_W-1:0] blk, input int stop_after);
    int   got = 0, cycles = 0, eob_edge = -1, target;
    bit   prev_stall = 1'b0;
    logic [RUN_W-1:0] h_run;
    logic [VAL_W-1:0] h_val;
    logic h_eob;
    build_expected(blk);
    target = (stop_after < 0) ? exp_q.size() : stop_after;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    mcu_in   = blk;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mcu_in   = {64{$urandom()}};
    while (got < target && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) check("dc_not_early", out_valid, 0);
      if (cycles == 2) check("dc_latency", out_valid, 1);
      check("in_ready_busy", in_ready, 0);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_run", out_run, h_run);
        check("hold_value", out_value, h_val);
        check("hold_eob", out_eob, h_eob);
      end
      if (out_valid && out_eob && eob_edge < 0) eob_edge = cycles - 1;
      if (out_valid && out_ready) begin
        check("run", out_run, exp_q[got].run);
        check("value", $signed(out_value), exp_q[got].value);
        check("eob", out_eob, exp_q[got].eob);
        got++;
      end
      prev_stall = out_valid && !out_ready;
      h_run = out_run; h_val = out_value; h_eob = out_eob;
    end
    check("tokens_seen", got, target);
    if (stop_after < 0) begin
      bc_exp = (bc_exp + 1) % 65536;
      if (!rnd_ready) check("eob_within_66", (eob_edge >= 0 && eob_edge <= 66) ? 1 : 0, 1);
      @(negedge clk);
      check("in_ready_after_eob", in_ready, 1);
      check("busy_after_eob", busy, 0);
      check("block_count", block_count, bc_exp);
    end
  endtask

  function automatic logic [64*COEF_W-1:0] set_coef(input logic [64*COEF_W-1:0] blk,
                                                    input int r, input int c, input logic [31:0] v);
    logic [64*COEF_W-1:0] b = blk;
    b[(r*8+c)*COEF_W +: COEF_W] = v;
    return b;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  initial begin
    logic [64*COEF_W-1:0] blk;
    make_zigzag();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    mcu_in   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_run", out_run, 0);
    check("rst_out_value", out_value, 0);
    check("rst_out_eob", out_eob, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_block_count", block_count, 0);

    // Directed blocks, consumer always ready.
    run_block('0, -1);
    blk = set_coef('0, 0, 0, 32'h500);
    blk = set_coef(blk, 0, 1, 32'h300);
    blk = set_coef(blk, 7, 7, 32'hFFFF_FE00);
    run_block(blk, -1);
    run_block(set_coef('0, 1, 0, 32'h180), -1);
    run_block(set_coef('0, 1, 0, 32'hFFFF_FE80), -1);
    run_block(set_coef('0, 1, 0, 32'h7F), -1);
    run_block(set_coef('0, 0, 0, 32'h7FFF_FF00), -1);
    run_block(set_coef('0, 0, 0, 32'h8000_0000), -1);
    blk = '0;
    for (int i = 0; i < 64; i++) blk = set_coef(blk, i / 8, i % 8, 32'h100 * (i + 1));
    run_block(blk, -1);

    // Random blocks under backpressure.
    rnd_ready = 1'b1;
    for (int b = 0; b < 100; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk = set_coef(blk, i / 8, i % 8, rand_coef());
      run_block(blk, -1);
    end

    // Reset in the middle of a block.
    rnd_ready = 1'b0;
    blk = '0;
    for (int i = 0; i < 64; i++) blk = set_coef(blk, i / 8, i % 8, 32'h200);
    run_block(blk, 3);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bc_exp  = 0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_block_count", block_count, 0);
    blk = set_coef('0, 2, 3, 32'hFFFF_F000);
    run_block(blk, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
